// File: rtl/instr_register_alu.sv
// ---------------------------------------------------------------------------------------------
// instr_register_alu
//
// DEPTH-entry instruction store. Each entry holds {opcode, operand_a, operand_b, result} plus a
// valid flag and a divide-by-zero flag. The result is computed before the entry is written:
// ALU ops and divide-by-zero take one cycle, DIV/MOD run a restoring divider for OP_WIDTH cycles.
//
// Parameters
//   OP_WIDTH    operand width, signed two's complement (>= 4)
//   DEPTH       number of entries, power of 2 (>= 2)
//   ADDR_WIDTH  $clog2(DEPTH)        (derived)
//   RES_WIDTH   2*OP_WIDTH           (derived, signed result)
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   load_en/load_ready  write handshake; opcode, operands and write_pointer captured on accept
//   opcode              ZERO=0 PASSA=1 PASSB=2 ADD=3 SUB=4 MULT=5 DIV=6 MOD=7
//   operand_a/b         signed operands (dividend / divisor for DIV, MOD)
//   write_pointer       target entry of the write
//   read_pointer        entry to read; rd_* are registered, one cycle latency
//   wr_done/_addr       one-cycle pulse while the entry is committed at the end of the cycle
//   rd_opcode/operand_a/operand_b/result/valid/dz   stored entry fields
//
// Optional feature (macro INSTR_REG_ERR_COUNT_EN)
//   instr_count[15:0]   commits since reset, saturating
//   dz_count[15:0]      commits with divide-by-zero since reset, saturating
// ---------------------------------------------------------------------------------------------
module instr_register_alu #(
    parameter int unsigned OP_WIDTH = 32,
    parameter int unsigned DEPTH    = 32,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
    localparam int unsigned RES_WIDTH  = 2 * OP_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_en,
    output logic                  load_ready,
    input  logic [2:0]            opcode,
    input  logic [OP_WIDTH-1:0]   operand_a,
    input  logic [OP_WIDTH-1:0]   operand_b,
    input  logic [ADDR_WIDTH-1:0] write_pointer,
    input  logic [ADDR_WIDTH-1:0] read_pointer,
    output logic                  wr_done,
    output logic [ADDR_WIDTH-1:0] wr_done_addr,
    output logic [2:0]            rd_opcode,
    output logic [OP_WIDTH-1:0]   rd_operand_a,
    output logic [OP_WIDTH-1:0]   rd_operand_b,
    output logic [RES_WIDTH-1:0]  rd_result,
    output logic                  rd_valid,
`ifdef INSTR_REG_ERR_COUNT_EN
    output logic [15:0]           instr_count,
    output logic [15:0]           dz_count,
`endif
    output logic                  rd_dz
);

    localparam int unsigned CNT_WIDTH = $clog2(OP_WIDTH);

    typedef enum logic [2:0] {
        OpZero  = 3'd0,
        OpPassA = 3'd1,
        OpPassB = 3'd2,
        OpAdd   = 3'd3,
        OpSub   = 3'd4,
        OpMult  = 3'd5,
        OpDiv   = 3'd6,
        OpMod   = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle,
        StDivide,
        StCommit
    } state_e;

    // -----------------------------------------------------------------------------------------
    // Control and captured operation
    // -----------------------------------------------------------------------------------------
    state_e                state_q;
    logic                  load_ready_q;
    logic                  wr_done_q;
    opcode_e               op_q;
    logic [OP_WIDTH-1:0]   a_q;
    logic [OP_WIDTH-1:0]   b_q;
    logic [ADDR_WIDTH-1:0] wp_q;

    // Divider state: quo_q starts as |dividend| and shifts out while quotient bits shift in.
    logic [OP_WIDTH-1:0]   quo_q;
    logic [OP_WIDTH-1:0]   rem_q;
    logic [OP_WIDTH-1:0]   dvsr_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  accept;
    logic                  needs_divider;
    logic [OP_WIDTH-1:0]   a_mag;
    logic [OP_WIDTH-1:0]   b_mag;

    assign accept        = load_en && load_ready_q;
    assign needs_divider = (opcode == OpDiv || opcode == OpMod) && (operand_b != '0);
    // Unsigned negation: the most negative value maps onto its true magnitude 2^(OP_WIDTH-1).
    assign a_mag         = operand_a[OP_WIDTH-1] ? -operand_a : operand_a;
    assign b_mag         = operand_b[OP_WIDTH-1] ? -operand_b : operand_b;

    // -----------------------------------------------------------------------------------------
    // Restoring divider step
    // -----------------------------------------------------------------------------------------
    logic [OP_WIDTH:0]   rem_shift;
    logic [OP_WIDTH:0]   trial;
    logic [OP_WIDTH-1:0] rem_d;
    logic [OP_WIDTH-1:0] quo_d;

    always_comb begin
        rem_shift = {rem_q, quo_q[OP_WIDTH-1]};
        trial     = rem_shift - {1'b0, dvsr_q};
        if (!trial[OP_WIDTH]) begin
            rem_d = trial[OP_WIDTH-1:0];
            quo_d = {quo_q[OP_WIDTH-2:0], 1'b1};
        end else begin
            rem_d = rem_shift[OP_WIDTH-1:0];
            quo_d = {quo_q[OP_WIDTH-2:0], 1'b0};
        end
    end

    // -----------------------------------------------------------------------------------------
    // Result formed in the commit cycle from captured operands / divider magnitudes
    // -----------------------------------------------------------------------------------------
    logic signed [RES_WIDTH-1:0] ext_a;
    logic signed [RES_WIDTH-1:0] ext_b;
    logic [RES_WIDTH-1:0]        quo_ext;
    logic [RES_WIDTH-1:0]        rem_ext;
    logic [RES_WIDTH-1:0]        quo_signed;
    logic [RES_WIDTH-1:0]        rem_signed;
    logic                        commit_dz;
    logic [RES_WIDTH-1:0]        commit_res;

    always_comb begin
        ext_a      = {{OP_WIDTH{a_q[OP_WIDTH-1]}}, a_q};
        ext_b      = {{OP_WIDTH{b_q[OP_WIDTH-1]}}, b_q};
        quo_ext    = {{OP_WIDTH{1'b0}}, quo_q};
        rem_ext    = {{OP_WIDTH{1'b0}}, rem_q};
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        quo_signed = (a_q[OP_WIDTH-1] ^ b_q[OP_WIDTH-1]) ? -quo_ext : quo_ext;
        rem_signed = a_q[OP_WIDTH-1] ? -rem_ext : rem_ext;
        commit_dz  = (op_q == OpDiv || op_q == OpMod) && (b_q == '0);
        commit_res = '0;
        unique case (op_q)
            OpZero:  commit_res = '0;
            OpPassA: commit_res = ext_a;
            OpPassB: commit_res = ext_b;
            OpAdd:   commit_res = ext_a + ext_b;
            OpSub:   commit_res = ext_a - ext_b;
            OpMult:  commit_res = ext_a * ext_b;
            OpDiv:   commit_res = commit_dz ? '0 : quo_signed;
            OpMod:   commit_res = commit_dz ? '0 : rem_signed;
            default: commit_res = '0;
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // FSM with registered handshake outputs
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            load_ready_q <= 1'b0;
            wr_done_q    <= 1'b0;
            op_q         <= OpZero;
            a_q          <= '0;
            b_q          <= '0;
            wp_q         <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            dvsr_q       <= '0;
            cnt_q        <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q         <= opcode_e'(opcode);
                        a_q          <= operand_a;
                        b_q          <= operand_b;
                        wp_q         <= write_pointer;
                        load_ready_q <= 1'b0;
                        if (needs_divider) begin
                            state_q <= StDivide;
                            quo_q   <= a_mag;
                            rem_q   <= '0;
                            dvsr_q  <= b_mag;
                            cnt_q   <= '0;
                        end else begin
                            state_q   <= StCommit;
                            wr_done_q <= 1'b1;
                        end
                    end else begin
                        load_ready_q <= 1'b1;
                    end
                end
                StDivide: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    if (cnt_q == CNT_WIDTH'(OP_WIDTH - 1)) begin
                        state_q   <= StCommit;
                        wr_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                StCommit: begin
                    state_q      <= StIdle;
                    wr_done_q    <= 1'b0;
                    load_ready_q <= 1'b1;
                end
                default: begin
                    state_q      <= StIdle;
                    wr_done_q    <= 1'b0;
                    load_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready   = load_ready_q;
    assign wr_done      = wr_done_q;
    assign wr_done_addr = wp_q;

    // -----------------------------------------------------------------------------------------
    // Entry storage
    // -----------------------------------------------------------------------------------------
    logic [2:0]           mem_op    [DEPTH];
    logic [OP_WIDTH-1:0]  mem_a     [DEPTH];
    logic [OP_WIDTH-1:0]  mem_b     [DEPTH];
    logic [RES_WIDTH-1:0] mem_res   [DEPTH];
    logic                 mem_valid [DEPTH];
    logic                 mem_dz    [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_op[i]    <= '0;
                mem_a[i]     <= '0;
                mem_b[i]     <= '0;
                mem_res[i]   <= '0;
                mem_valid[i] <= 1'b0;
                mem_dz[i]    <= 1'b0;
            end
        end else if (state_q == StCommit) begin
            mem_op[wp_q]    <= op_q;
            mem_a[wp_q]     <= a_q;
            mem_b[wp_q]     <= b_q;
            mem_res[wp_q]   <= commit_res;
            mem_valid[wp_q] <= 1'b1;
            mem_dz[wp_q]    <= commit_dz;
        end
    end

    // Registered read: a commit on the same edge is visible one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_opcode    <= '0;
            rd_operand_a <= '0;
            rd_operand_b <= '0;
            rd_result    <= '0;
            rd_valid     <= 1'b0;
            rd_dz        <= 1'b0;
        end else begin
            rd_opcode    <= mem_op[read_pointer];
            rd_operand_a <= mem_a[read_pointer];
            rd_operand_b <= mem_b[read_pointer];
            rd_result    <= mem_res[read_pointer];
            rd_valid     <= mem_valid[read_pointer];
            rd_dz        <= mem_dz[read_pointer];
        end
    end

`ifdef INSTR_REG_ERR_COUNT_EN
    // -----------------------------------------------------------------------------------------
    // Saturating commit counters
    // -----------------------------------------------------------------------------------------
    logic [15:0] instr_count_q;
    logic [15:0] dz_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_count_q <= '0;
            dz_count_q    <= '0;
        end else if (state_q == StCommit) begin
            if (instr_count_q != 16'hFFFF) begin
                instr_count_q <= instr_count_q + 16'd1;
            end
            if (commit_dz && dz_count_q != 16'hFFFF) begin
                dz_count_q <= dz_count_q + 16'd1;
            end
        end
    end

    assign instr_count = instr_count_q;
    assign dz_count    = dz_count_q;
`endif

endmodule

// File: tb/tb_instr_register_alu.sv
// Bench for instr_register_alu: directed vectors, a transaction-level reference model and a
// per-cycle compare process, plus hand-computed literal checks.
module tb_instr_register_alu;

    localparam int unsigned OPW   = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned RW    = 64;

    localparam logic [2:0] ZERO = 3'd0, PASSA = 3'd1, PASSB = 3'd2, ADD = 3'd3;
    localparam logic [2:0] SUB = 3'd4, MULT = 3'd5, DIV = 3'd6, MOD = 3'd7;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           load_en = 1'b0;
    logic           load_ready;
    logic [2:0]     opcode = '0;
    logic [OPW-1:0] operand_a = '0;
    logic [OPW-1:0] operand_b = '0;
    logic [AW-1:0]  write_pointer = '0;
    logic [AW-1:0]  read_pointer = '0;
    logic           wr_done;
    logic [AW-1:0]  wr_done_addr;
    logic [2:0]     rd_opcode;
    logic [OPW-1:0] rd_operand_a;
    logic [OPW-1:0] rd_operand_b;
    logic [RW-1:0]  rd_result;
    logic           rd_valid;
    logic           rd_dz;
`ifdef INSTR_REG_ERR_COUNT_EN
    logic [15:0]    instr_count;
    logic [15:0]    dz_count;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    instr_register_alu #(
        .OP_WIDTH(OPW),
        .DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_en      (load_en),
        .load_ready   (load_ready),
        .opcode       (opcode),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .write_pointer(write_pointer),
        .read_pointer (read_pointer),
        .wr_done      (wr_done),
        .wr_done_addr (wr_done_addr),
        .rd_opcode    (rd_opcode),
        .rd_operand_a (rd_operand_a),
        .rd_operand_b (rd_operand_b),
        .rd_result    (rd_result),
        .rd_valid     (rd_valid),
`ifdef INSTR_REG_ERR_COUNT_EN
        .instr_count  (instr_count),
        .dz_count     (dz_count),
`endif
        .rd_dz        (rd_dz)
    );

    task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out waiting on the DUT", name);
    endtask

    // ------------------------------------------------------------------------------------------
    // Reference model: entries as plain records, results from SV integer arithmetic
    // ------------------------------------------------------------------------------------------
    typedef struct {
        logic [2:0]     op;
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        logic [RW-1:0]  res;
        logic           valid;
        logic           dz;
    } ent_t;

    ent_t          m_mem[DEPTH];
    ent_t          m_rd;
    ent_t          m_cur;
    bit            m_ready;
    bit            m_pend;
    bit            m_done;
    int            m_left;
    logic [AW-1:0] m_wp;
    int            m_icnt;
    int            m_dcnt;

    function automatic ent_t eval(input logic [2:0] op, input logic [OPW-1:0] a,
                                  input logic [OPW-1:0] b);
        ent_t   e;
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.op = op;
        e.a = a;
        e.b = b;
        e.valid = 1'b1;
        e.dz = 1'b0;
        case (op)
            ZERO:  r = 0;
            PASSA: r = sa;
            PASSB: r = sb;
            ADD:   r = sa + sb;
            SUB:   r = sa - sb;
            MULT:  r = sa * sb;
            DIV:   if (sb == 0) begin r = 0; e.dz = 1'b1; end else r = sa / sb;
            default: if (sb == 0) begin r = 0; e.dz = 1'b1; end else r = sa % sb;
        endcase
        e.res = r;
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '{default: '0};
        m_rd = '{default: '0};
        m_ready = 0;
        m_pend = 0;
        m_done = 0;
        m_left = 0;
        m_wp = '0;
        m_icnt = 0;
        m_dcnt = 0;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_clear();
            end else begin
                m_rd = m_mem[read_pointer];
                if (m_pend) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mem[m_wp] = m_cur;
                        if (m_icnt < 65535) m_icnt++;
                        if (m_cur.dz && m_dcnt < 65535) m_dcnt++;
                        m_pend = 0;
                    end
                end else if (m_ready && load_en) begin
                    m_cur  = eval(opcode, operand_a, operand_b);
                    m_wp   = write_pointer;
                    m_pend = 1;
                    m_left = (opcode >= DIV && operand_b != 0) ? OPW + 1 : 1;
                end
                m_ready = !m_pend;
                m_done  = m_pend && (m_left == 1);
            end
        end
    end

    // Compare DUT against model every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("load_ready", load_ready, m_ready);
            chk("wr_done", wr_done, m_done);
            if (m_done) chk("wr_done_addr", wr_done_addr, m_wp);
            chk("rd_opcode", rd_opcode, m_rd.op);
            chk("rd_operand_a", rd_operand_a, m_rd.a);
            chk("rd_operand_b", rd_operand_b, m_rd.b);
            chk("rd_result", rd_result, m_rd.res);
            chk("rd_valid", rd_valid, m_rd.valid);
            chk("rd_dz", rd_dz, m_rd.dz);
`ifdef INSTR_REG_ERR_COUNT_EN
            chk("instr_count", instr_count, m_icnt);
            chk("dz_count", dz_count, m_dcnt);
`endif
        end
    end

    // ------------------------------------------------------------------------------------------
    // Stimulus helpers (all called at a negedge)
    // ------------------------------------------------------------------------------------------
    task automatic wait_ready();
        int n = 0;
        while (!load_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!load_ready) fail_timeout("wait_ready");
    endtask

    // Returns at the negedge following the accept edge.
    task automatic issue(input logic [2:0] op, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                         input logic [AW-1:0] wp);
        wait_ready();
        opcode = op;
        operand_a = a;
        operand_b = b;
        write_pointer = wp;
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Returns at the negedge after the commit edge.
    task automatic wait_done();
        int n = 0;
        while (!wr_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!wr_done) fail_timeout("wait_done");
        @(negedge clk);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [OPW-1:0] a,
                          input logic [OPW-1:0] b, input logic [AW-1:0] wp);
        issue(op, a, b, wp);
        wait_done();
    endtask

    task automatic read_at(input logic [AW-1:0] rp);
        read_pointer = rp;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int n_done;

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("ready_in_reset", load_ready, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", load_ready, 1'b1);
        for (int i = 0; i < int'(DEPTH); i++) begin
            read_at(i[AW-1:0]);
            chk("idle_valid", rd_valid, 1'b0);
            chk("idle_result", rd_result, 64'd0);
        end

        // ADD 7 + -3 into entry 5
        issue(ADD, 7, -3, 5);
        chk("add_wr_done", wr_done, 1'b1);
        chk("add_wr_addr", wr_done_addr, 5);
        @(negedge clk);
        read_at(5);
        chk("add_result", rd_result, 64'd4);
        chk("add_valid", rd_valid, 1'b1);
        chk("add_dz", rd_dz, 1'b0);

        // DIV -7 / 2: busy for OP_WIDTH+1 cycles
        issue(DIV, -7, 2, 1);
        n = 0;
        while (!load_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("div_busy_cycles", n, OPW + 1);
        read_at(1);
        chk("div_result", rd_result, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(MOD, -7, 2, 3);
        read_at(3);
        chk("mod_result", rd_result, 64'hFFFF_FFFF_FFFF_FFFF);

        // Divide by zero commits after one cycle
        issue(DIV, 9, 0, 2);
        chk("div0_fast_commit", wr_done, 1'b1);
        @(negedge clk);
        read_at(2);
        chk("div0_result", rd_result, 64'd0);
        chk("div0_dz", rd_dz, 1'b1);

        run_op(MULT, 32'h8000_0000, 32'h8000_0000, 4);
        read_at(4);
        chk("mult_min_min", rd_result, 64'h4000_0000_0000_0000);

        run_op(DIV, 32'h8000_0000, -1, 6);
        read_at(6);
        chk("div_min_m1", rd_result, 64'h0000_0000_8000_0000);

        run_op(MOD, 7, -2, 11);
        read_at(11);
        chk("mod_7_m2", rd_result, 64'd1);
        run_op(DIV, -100, 7, 12);
        read_at(12);
        chk("div_m100_7", rd_result, 64'hFFFF_FFFF_FFFF_FFF2);
        run_op(MOD, -100, 7, 13);
        read_at(13);
        chk("mod_m100_7", rd_result, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(MOD, 5, 0, 14);
        run_op(PASSA, -5, 9, 15);
        run_op(PASSB, 1, -9, 16);
        run_op(SUB, 3, 10, 17);
        read_at(17);
        chk("sub_3_10", rd_result, 64'hFFFF_FFFF_FFFF_FFF9);
        run_op(ZERO, 123, 456, 5);
        read_at(5);
        chk("zero_overwrite", rd_result, 64'd0);
        chk("zero_overwrite_a", rd_operand_a, 123);

        // load_en held high during a DIV: exactly one accept
        wait_ready();
        opcode = DIV;
        operand_a = 20;
        operand_b = 3;
        write_pointer = 7;
        load_en = 1'b1;
        n_done = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (wr_done) begin
                n_done++;
                load_en = 1'b0;
            end
        end
        load_en = 1'b0;
        chk("held_one_accept", n_done, 1);
        read_at(7);
        chk("held_div_result", rd_result, 64'd6);

        // Reset pulse mid-DIVIDE: nothing written, all entries cleared
        issue(DIV, 50, 5, 8);
        repeat (5) @(negedge clk);
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_pulse", load_ready, 1'b1);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            read_pointer = 8;
            @(negedge clk);
            if (wr_done) n_done++;
        end
        chk("aborted_no_commit", n_done, 0);
        chk("aborted_entry_invalid", rd_valid, 1'b0);
        read_at(1);
        chk("cleared_entry_invalid", rd_valid, 1'b0);

        // Read of the entry committed on the same edge
        run_op(ADD, 1, 1, 9);
        read_at(9);
        chk("pre_overwrite", rd_result, 64'd2);
        wait_ready();
        read_pointer = 9;
        opcode = SUB;
        operand_a = 10;
        operand_b = 3;
        write_pointer = 9;
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        @(negedge clk);
        chk("same_edge_old", rd_result, 64'd2);
        @(negedge clk);
        chk("same_edge_new", rd_result, 64'd7);

        run_op(DIV, 9, 0, 10);
`ifdef INSTR_REG_ERR_COUNT_EN
        chk("instr_count_3", instr_count, 16'd3);
        chk("dz_count_1", dz_count, 16'd1);
`endif

        // Final sweep of all entries against the model
        for (int i = 0; i < int'(DEPTH); i++) read_at(i[AW-1:0]);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
